// File: rtl/lr35902_lcd_pkg.sv
`default_nettype none
// ============================================================================
// lr35902_lcd_pkg : shared LCD geometry constants and sink state encoding
// Revision 1.0
// ============================================================================
package lr35902_lcd_pkg;

  localparam int LCD_WIDTH       = 160;
  localparam int LCD_HEIGHT      = 144;
  localparam int PX_PER_BYTE     = 4;
  localparam int BYTES_PER_FRAME = (LCD_WIDTH * LCD_HEIGHT) / PX_PER_BYTE;

  localparam logic [7:0]  X_LAST   = 8'(LCD_WIDTH - 1);
  localparam logic [7:0]  Y_LAST   = 8'(LCD_HEIGHT - 1);
  localparam logic [1:0]  SUB_LAST = 2'(PX_PER_BYTE - 1);
  localparam int          WRQ_W    = 13 + 8;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_WAIT_SYNC = 2'd2
  } lcd_state_e;

endpackage
`default_nettype wire

// File: rtl/lr35902_lcd_wrq.sv
`default_nettype none
// ============================================================================
// lr35902_lcd_wrq : two-entry write queue; head is always visible on data_o
// Revision 1.0
// ============================================================================
module lr35902_lcd_wrq #(
  parameter int               WIDTH   = 21,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             w_push;
  logic             w_pop;

  assign valid_o = (count_q != 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign data_o  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the write pointer targets.
  assign w_pop  = pop_i && valid_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= RST_VAL;
      mem_q[1] <= RST_VAL;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lr35902_lcd_sink.sv
`default_nettype none
// ============================================================================
// lr35902_lcd_sink : packs PPU pixels 4-per-byte and queues framebuffer writes
// Revision 1.0
// ============================================================================
module lr35902_lcd_sink
  import lr35902_lcd_pkg::*;
#(
  parameter logic [12:0] FB_BASE = 13'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_on,
  input  logic        px_out,
  input  logic [1:0]  px,
  input  logic        vsync,
  output logic [12:0] fb_adr,
  output logic [7:0]  fb_dout,
  output logic        fb_write,
  input  logic        fb_ready,
  output logic        frame_done,
  output logic        overflow
);

  lcd_state_e  state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [1:0]  sub_q, sub_d;
  logic [12:0] byte_q, byte_d;
  logic [5:0]  shift_q, shift_d;
  logic        frame_done_q, frame_done_d;
  logic        overflow_q, overflow_d;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [WRQ_W-1:0] w_head;
  logic [12:0]      w_addr;

  assign w_addr = FB_BASE + byte_q;
  assign w_pop  = fb_write && fb_ready;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sub_d        = sub_q;
    byte_d       = byte_q;
    shift_d      = shift_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    w_push       = 1'b0;

    if (!disp_on) begin
      state_d = ST_OFF;
      x_d     = '0;
      y_d     = '0;
      sub_d   = '0;
      byte_d  = '0;
      if (state_q != ST_OFF) begin
        overflow_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          sub_d   = '0;
          byte_d  = '0;
        end
        ST_ACTIVE: begin
          if (vsync) begin
            x_d    = '0;
            y_d    = '0;
            sub_d  = '0;
            byte_d = '0;
          end else if (px_out) begin
            shift_d = {shift_q[3:0], px};
            if (sub_q == SUB_LAST) begin
              w_push = 1'b1;
              sub_d  = '0;
              byte_d = byte_q + 13'd1;
            end else begin
              sub_d = sub_q + 2'd1;
            end
            if (x_q == X_LAST) begin
              x_d = '0;
              // Line width is a multiple of 4, so the last pixel always closes a byte.
              if (y_q == Y_LAST) begin
                y_d          = '0;
                byte_d       = '0;
                state_d      = ST_WAIT_SYNC;
                frame_done_d = 1'b1;
              end else begin
                y_d = y_q + 8'd1;
              end
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
        ST_WAIT_SYNC: begin
          if (vsync) begin
            state_d = ST_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            sub_d   = '0;
            byte_d  = '0;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    if (w_push && w_full && !w_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OFF;
      x_q          <= '0;
      y_q          <= '0;
      sub_q        <= '0;
      byte_q       <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sub_q        <= sub_d;
      byte_q       <= byte_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  lr35902_lcd_wrq #(
    .WIDTH   (WRQ_W),
    .RST_VAL ({FB_BASE, 8'h00})
  ) u_wrq (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .data_i  ({w_addr, shift_q, px}),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .valid_o (fb_write),
    .data_o  (w_head)
  );

  assign fb_adr     = w_head[WRQ_W-1:8];
  assign fb_dout    = w_head[7:0];
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_lr35902_lcd_sink.sv
`default_nettype none
// ============================================================================
// tb_lr35902_lcd_sink : directed scoreboard bench for the LCD pixel sink
// Revision 1.0
// ============================================================================
module tb_lr35902_lcd_sink;

  localparam logic [12:0] FB_BASE = 13'h1F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_on;
  logic        px_out;
  logic [1:0]  px;
  logic        vsync;
  logic [12:0] fb_adr;
  logic [7:0]  fb_dout;
  logic        fb_write;
  logic        fb_ready;
  logic        frame_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int fd_count = 0;

  logic [20:0] exp_q [$];
  logic [20:0] mon_exp;
  logic [20:0] prev_head;
  logic        have_prev = 1'b0;

  logic [7:0]  m_acc = '0;
  int          m_cnt = 0;
  logic [12:0] m_addr = '0;

  lr35902_lcd_sink #(.FB_BASE(FB_BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_on    (disp_on),
    .px_out     (px_out),
    .px         (px),
    .vsync      (vsync),
    .fb_adr     (fb_adr),
    .fb_dout    (fb_dout),
    .fb_write   (fb_write),
    .fb_ready   (fb_ready),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Accepted writes are popped against the scoreboard; held writes must not move.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
    if (reset) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        chk("hold_write", {31'd0, fb_write}, 32'd1);
        chk("hold_entry", {11'd0, fb_adr, fb_dout}, {11'd0, prev_head});
      end
      if (fb_write && fb_ready) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          chk("spurious_write", {31'd0, fb_write}, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("write_adr", {19'd0, fb_adr}, {19'd0, mon_exp[20:8]});
          chk("write_data", {24'd0, fb_dout}, {24'd0, mon_exp[7:0]});
        end
      end
      have_prev = fb_write && !fb_ready;
      prev_head = {fb_adr, fb_dout};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_restart();
    m_cnt  = 0;
    m_addr = '0;
  endtask

  task automatic send_px(input logic [1:0] p, input bit keep);
    m_acc = {m_acc[5:0], p};
    m_cnt++;
    if (m_cnt == 4) begin
      if (keep) exp_q.push_back({FB_BASE + m_addr, m_acc});
      m_addr = m_addr + 13'd1;
      m_cnt  = 0;
    end
    px_out = 1'b1;
    px     = p;
    tick();
    px_out = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    model_restart();
  endtask

  int wr_before;

  initial begin
    reset = 1'b1; disp_on = 1'b0; px_out = 1'b0; px = 2'd0; vsync = 1'b0; fb_ready = 1'b1;
    tick();
    chk("rst_fb_write", {31'd0, fb_write}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_fb_adr", {19'd0, fb_adr}, {19'd0, FB_BASE});
    chk("rst_fb_dout", {24'd0, fb_dout}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Pixels while OFF are ignored.
    send_px(2'd3, 1'b0); send_px(2'd3, 1'b0); send_px(2'd3, 1'b0); send_px(2'd3, 1'b0);
    chk("off_no_write", {31'd0, fb_write}, 32'd0);
    disp_on = 1'b1;
    tick();
    model_restart();

    // Single byte, one-cycle latency.
    send_px(2'd3, 1'b1); send_px(2'd2, 1'b1); send_px(2'd1, 1'b1);
    chk("early_no_write", {31'd0, fb_write}, 32'd0);
    send_px(2'd0, 1'b1);
    chk("latency_fb_write", {31'd0, fb_write}, 32'd1);
    chk("first_dout", {24'd0, fb_dout}, 32'hE4);
    repeat (3) tick();

    // Short frame: vsync drops the partial byte and restarts addressing.
    pulse_vsync();
    for (int i = 0; i < 6; i++) send_px(2'(i + 1), 1'b1);
    pulse_vsync();
    for (int i = 0; i < 4; i++) send_px(2'd1, 1'b1);
    repeat (3) tick();
    chk("short_frame_no_done", fd_count, 0);
    chk("short_drained", exp_q.size(), 0);

    // Overflow: two queued, third dropped.
    pulse_vsync();
    fb_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_px(2'(i * 3), (i < 8));
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_head_adr", {19'd0, fb_adr}, {19'd0, FB_BASE});
    wr_before = wr_count;
    fb_ready = 1'b1;
    repeat (5) tick();
    chk("ovf_write_count", wr_count - wr_before, 2);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Display off drains the queue, drops the partial byte, clears overflow.
    pulse_vsync();
    fb_ready = 1'b0;
    send_px(2'd0, 1'b1); send_px(2'd1, 1'b1); send_px(2'd3, 1'b1); send_px(2'd2, 1'b1);
    send_px(2'd3, 1'b1); send_px(2'd3, 1'b1);
    chk("pre_off_ovf", {31'd0, overflow}, 32'd1);
    disp_on = 1'b0;
    tick();
    model_restart();
    chk("off_ovf_clear", {31'd0, overflow}, 32'd0);
    chk("off_still_pending", {31'd0, fb_write}, 32'd1);
    wr_before = wr_count;
    fb_ready = 1'b1;
    repeat (4) tick();
    chk("off_drain_count", wr_count - wr_before, 1);
    disp_on = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_px(2'd2, 1'b1);
    repeat (3) tick();
    chk("reon_drained", exp_q.size(), 0);

    // Full frame.
    pulse_vsync();
    wr_before = wr_count;
    fd_count  = 0;
    for (int i = 0; i < 160 * 144 - 1; i++) send_px(2'($urandom_range(0, 3)), 1'b1);
    chk("frame_no_early_done", fd_count, 0);
    send_px(2'd3, 1'b1);
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    tick();
    chk("frame_done_low", {31'd0, frame_done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      px_out = 1'b1; px = 2'd3; tick();
    end
    px_out = 1'b0;
    repeat (4) tick();
    chk("frame_write_count", wr_count - wr_before, 5760);
    chk("frame_done_count", fd_count, 1);
    chk("frame_drained", exp_q.size(), 0);
    pulse_vsync();
    send_px(2'd1, 1'b1); send_px(2'd1, 1'b1); send_px(2'd2, 1'b1); send_px(2'd2, 1'b1);
    repeat (3) tick();
    chk("after_vsync_drained", exp_q.size(), 0);

    // Asynchronous reset abandons a pending write.
    pulse_vsync();
    fb_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_px(2'd3, 1'b0);
    chk("pre_rst_write", {31'd0, fb_write}, 32'd1);
    chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_fb_write", {31'd0, fb_write}, 32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    chk("arst_fb_adr", {19'd0, fb_adr}, {19'd0, FB_BASE});
    tick();
    tick();
    reset = 1'b0;
    model_restart();
    fb_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", {31'd0, fb_write}, 32'd0);
    send_px(2'd0, 1'b1); send_px(2'd1, 1'b1); send_px(2'd2, 1'b1); send_px(2'd3, 1'b1);
    chk("post_rst_dout", {24'd0, fb_dout}, 32'h1B);
    repeat (3) tick();
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
